// File: rtl/sine_voice_scheduler.sv
// Time-multiplexes one 256x12 synchronous sine ROM among NUM_VOICES DDS voices and mixes them per sample tick.
// Define MIX_CLIP_EN to saturate the loaded mix word to the 12-bit signed range.
module sine_voice_scheduler #(
    parameter int  NUM_VOICES = 4,
    parameter int  PHASE_W    = 24,
    localparam int MIX_W      = 12 + $clog2(NUM_VOICES),
    localparam int SEL_W      = $clog2(NUM_VOICES)
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  sample_tick,
    input  logic [NUM_VOICES-1:0] voice_en,
    input  logic                  inc_wr,
    input  logic [SEL_W-1:0]      inc_sel,
    input  logic [PHASE_W-1:0]    inc_data,
    output logic [7:0]            rom_address,
    input  logic [11:0]           rom_q,
    output logic [MIX_W-1:0]      mix_out,
    output logic                  mix_valid,
    output logic                  busy,
    output logic                  overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     v_q, v_d;
    logic [PHASE_W-1:0]   phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]   phase_d [NUM_VOICES];
    logic [PHASE_W-1:0]   inc_q   [NUM_VOICES];
    logic [PHASE_W-1:0]   inc_d   [NUM_VOICES];
    logic [7:0]           rom_address_q, rom_address_d;
    logic                 vld1_q, vld1_d;
    logic                 vld2_q, vld2_d;
    logic [MIX_W-1:0]     acc_q, acc_d;
    logic [MIX_W-1:0]     mix_out_q, mix_out_d;
    logic                 mix_valid_q, mix_valid_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic [11:0]          sample_s;
    logic [MIX_W-1:0]     addend_s;

`ifdef MIX_CLIP_EN
    localparam logic signed [MIX_W-1:0] CLIP_HI = MIX_W'(2047);
    localparam logic signed [MIX_W-1:0] CLIP_LO = ~CLIP_HI;

    function automatic logic [MIX_W-1:0] clip12(input logic [MIX_W-1:0] x);
        logic signed [MIX_W-1:0] s;
        s = $signed(x);
        if (s > CLIP_HI) begin
            clip12 = CLIP_HI;
        end else if (s < CLIP_LO) begin
            clip12 = CLIP_LO;
        end else begin
            clip12 = x;
        end
    endfunction
`endif

    // Offset-binary ROM word to two's complement; vld2_q marks the ROM return of an enabled slot
    assign sample_s = {~rom_q[11], rom_q[10:0]};
    assign addend_s = vld2_q ? {{(MIX_W-12){sample_s[11]}}, sample_s} : {MIX_W{1'b0}};

    // Sweep sequencing, phase advance, increment writes and mix accumulation
    always_comb begin
        state_d       = state_q;
        v_d           = v_q;
        phase_d       = phase_q;
        inc_d         = inc_q;
        rom_address_d = rom_address_q;
        vld1_d        = 1'b0;
        vld2_d        = vld1_q;
        acc_d         = acc_q + addend_s;
        mix_out_d     = mix_out_q;
        mix_valid_d   = 1'b0;
        busy_d        = busy_q;
        overrun_d     = overrun_q;

        if (inc_wr && (int'(inc_sel) < NUM_VOICES)) begin
            inc_d[inc_sel] = inc_data;
        end else begin
            inc_d = inc_q;
        end

        if (sample_tick && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            S_IDLE: begin
                acc_d = {MIX_W{1'b0}};
                v_d   = {SEL_W{1'b0}};
                if (sample_tick) begin
                    state_d = S_ISSUE;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                rom_address_d = phase_q[v_q][PHASE_W-1 -: 8];
                // inc_q (not inc_d) so a same-cycle write only affects the next advance
                if (voice_en[v_q]) begin
                    phase_d[v_q] = phase_q[v_q] + inc_q[v_q];
                    vld1_d       = 1'b1;
                end else begin
                    phase_d[v_q] = {PHASE_W{1'b0}};
                    vld1_d       = 1'b0;
                end
                if (v_q == SEL_W'(NUM_VOICES - 1)) begin
                    v_d     = {SEL_W{1'b0}};
                    state_d = S_DRAIN;
                end else begin
                    v_d = v_q + SEL_W'(1);
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                // acc_d already contains the final voice, whose ROM word returns during this cycle
`ifdef MIX_CLIP_EN
                mix_out_d = clip12(acc_d);
`else
                mix_out_d = acc_d;
`endif
                mix_valid_d = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            v_q           <= {SEL_W{1'b0}};
            rom_address_q <= 8'h00;
            vld1_q        <= 1'b0;
            vld2_q        <= 1'b0;
            acc_q         <= {MIX_W{1'b0}};
            mix_out_q     <= {MIX_W{1'b0}};
            mix_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= {PHASE_W{1'b0}};
                inc_q[i]   <= {PHASE_W{1'b0}};
            end
        end else begin
            state_q       <= state_d;
            v_q           <= v_d;
            rom_address_q <= rom_address_d;
            vld1_q        <= vld1_d;
            vld2_q        <= vld2_d;
            acc_q         <= acc_d;
            mix_out_q     <= mix_out_d;
            mix_valid_q   <= mix_valid_d;
            busy_q        <= busy_d;
            overrun_q     <= overrun_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= phase_d[i];
                inc_q[i]   <= inc_d[i];
            end
        end
    end

    assign rom_address = rom_address_q;
    assign mix_out     = mix_out_q;
    assign mix_valid   = mix_valid_q;
    assign busy        = busy_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/sine_voice_scheduler.md
Name: sine_voice_scheduler

Overview:
- Time-multiplexes one 256x12 sine ROM (1-cycle synchronous read, offset-binary samples) among NUM_VOICES DDS voices.
- On each audio sample tick it walks every voice in order:
  - presents that voice's phase MSBs to the ROM,
  - advances the voice's phase accumulator,
  - sums the returned signed samples into one mix word.
- Sits between the sequencer step logic, which supplies per-voice phase increments and gates, and the audio output path.

Parameters:
- NUM_VOICES, 4: voice count, 2..16.
- PHASE_W, 24: phase accumulator and increment width. ROM address = phase[PHASE_W-1 -: 8].
- MIX_W, 12+$clog2(NUM_VOICES): signed mix width, derived (localparam).

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- sample_tick  in  1  one-cycle pulse at the audio sample rate.
- voice_en  in  NUM_VOICES  per-voice gate, level.
- inc_wr  in  1  increment write strobe.
- inc_sel  in  $clog2(NUM_VOICES)  voice index for inc_wr.
- inc_data  in  PHASE_W  phase increment value.
- rom_address  out  8  to ROM address.
- rom_q  in  12  from ROM q; valid 1 cycle after rom_address is presented.
- mix_out  out  MIX_W  signed mixed sample; holds between updates.
- mix_valid  out  1  one-cycle pulse when mix_out is updated.
- busy  out  1  high while a sweep is in progress.
- overrun  out  1  sticky; set by a sample_tick arriving while busy.

Behaviour:
- Reset (asynchronous, resetn=0): all outputs 0; all phase and increment registers 0; accumulator 0; FSM to IDLE.
- Increment write: inc_wr writes inc_data to inc[inc_sel] at the clock edge, in any state.
  - A write landing in the same cycle as that voice's ISSUE slot does not affect that slot; the old value is used for that advance.
  - inc_sel >= NUM_VOICES: write ignored.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - sample_tick=1 → ISSUE with v=0.
  - Accumulator cleared.
  - busy goes 1 on the next cycle.
- ISSUE (NUM_VOICES cycles, v = 0..NUM_VOICES-1):
  - rom_address <= phase[v] MSBs (registered).
  - If voice_en[v]=1 (sampled this cycle): phase[v] <= phase[v] + inc[v], modulo 2^PHASE_W wrap; valid bit for the slot = 1.
  - If voice_en[v]=0: phase[v] <= 0 so the next note restarts at address 0; valid bit = 0.
  - Cycle after each slot: if its valid bit is set, accumulator += {~rom_q[11], rom_q[10:0]}, sign-extended to MIX_W. Disabled slots add 0.
  - After v = NUM_VOICES-1 → DRAIN.
- DRAIN (1 cycle): absorbs the last ROM return → DONE.
- DONE (1 cycle):
  - mix_out <= accumulator; mix_valid=1 for exactly this cycle.
  - busy=0 from the next cycle; → IDLE.
- Latency: sample_tick at cycle T → mix_valid at cycle T+NUM_VOICES+3.
- sample_tick while busy (ISSUE/DRAIN/DONE): ignored; overrun <= 1.
  - overrun clears only on reset.
  - Phases are not advanced for the dropped tick.
- Arithmetic: MIX_W holds worst case NUM_VOICES × −2048 without overflow. Phase add is unsigned and wraps.
- voice_en changing mid-sweep: each voice uses its value at its own ISSUE slot.
- Reset mid-sweep: immediate return to reset state; no mix_valid.

Optional Feature:
- Macro: MIX_CLIP_EN.
- Defined: the value loaded into mix_out in DONE is saturated to −2048..+2047 and sign-extended to MIX_W, so the output stays DAC-safe at 12 bits.
- Undefined: full-precision sum, no saturation.

Test Plan:
(Bench ROM is a ramp, mem[a] = {a,4'h0}, 1-cycle latency. NUM_VOICES=4, PHASE_W=24.)
1. Reset, then release; voice_en=0, one sample_tick → all outputs 0 until mix_valid at T+7 with mix_out=0.
2. inc[0]=0x010000, voice_en=4'b0001, three ticks → rom_address for voice 0 is 0x00, 0x01, 0x02; mix_out = -2048, -2032, -2016.
3. All four voices enabled with inc=0x010000; phases preloaded by running 128 ticks; next tick → addresses 0x80 each; mix_out = 4×0 = 0. Then at address 0xFF: 4×2032 = 8128.
4. Wrap: inc[1]=0xFF0000 → voice 1 address sequence 0x00, 0xFF, 0xFE; no carry out of the accumulator.
5. Second sample_tick pulsed 2 cycles after the first → overrun=1 and stays 1; only one mix_valid; phases advance once.
6. Four voices at address 0xFF with MIX_CLIP_EN defined → mix_out=2047. Without MIX_CLIP_EN → 8128. Also: assert resetn mid-ISSUE → no mix_valid, busy=0.
